// File: rtl/census_frame_ctrl_if.sv
// Stream, census-beat and output-qualifier signals of census_frame_ctrl.
// The controller takes the slave side; the frame source / census consumer takes master.
interface census_frame_ctrl_if #(
    parameter int N  = 8,
    parameter int CW = 16
);
    logic          i_start;
    logic [N-1:0]  i_pix_data;
    logic          i_pix_valid;
    logic          o_pix_ready;
    logic [N-1:0]  o_ct_data;
    logic          o_ct_dval;
    logic          o_out_valid;
    logic [CW-1:0] o_out_x;
    logic [CW-1:0] o_out_y;
    logic          o_border;
    logic          o_busy;
    logic          o_frame_done;

    modport slave (
        input  i_start, i_pix_data, i_pix_valid,
        output o_pix_ready, o_ct_data, o_ct_dval, o_out_valid,
               o_out_x, o_out_y, o_border, o_busy, o_frame_done
    );

    modport master (
        output i_start, i_pix_data, i_pix_valid,
        input  o_pix_ready, o_ct_data, o_ct_dval, o_out_valid,
               o_out_x, o_out_y, o_border, o_busy, o_frame_done
    );
endinterface

// File: rtl/census_frame_ctrl.sv
// Frame sequencer for census_transform: streams one ROWS x M frame, appends drain
// beats, and emits an (x,y,border) qualifier aligned to the census output registers.
module census_frame_ctrl #(
    parameter int M    = 50,
    parameter int ROWS = 50,
    parameter int WC   = 3,
    parameter int N    = 8,
    parameter int CW   = 16
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    census_frame_ctrl_if.slave bus
);
    localparam int H         = (WC - 1) / 2;
    localparam int FLUSH_LEN = ((WC - 1) * M + (WC - 1)) / 2 + 1;
    localparam int TOTAL     = ROWS * M + FLUSH_LEN;
    localparam int BW        = $clog2(TOTAL + 1);
    localparam int FW        = $clog2(FLUSH_LEN + 1);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] in_col_q, in_col_d, in_row_q, in_row_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [FW-1:0] flush_q, flush_d;
    logic [CW-1:0] oc_q, oc_d, or_q, or_d;
    logic [N-1:0]  ct_data_q, ct_data_d;
    logic          ct_dval_q, ct_dval_d;
    logic          ov_q, ov_d;
    logic [CW-1:0] ox_q, ox_d, oy_q, oy_d;
    logic          bord_q, bord_d;
    logic          accept, edge_pix;

    assign bus.o_pix_ready  = (state_q == STREAM);
    assign accept           = bus.i_pix_valid && (state_q == STREAM);
    assign edge_pix         = (oc_q < CW'(H)) || (oc_q > CW'(M - 1 - H)) ||
                              (or_q < CW'(H)) || (or_q > CW'(ROWS - 1 - H));
    assign bus.o_ct_data    = ct_data_q;
    assign bus.o_ct_dval    = ct_dval_q;
    assign bus.o_out_valid  = ov_q;
    assign bus.o_out_x      = ox_q;
    assign bus.o_out_y      = oy_q;
    assign bus.o_border     = bord_q;
    assign bus.o_busy       = (state_q != IDLE);
    assign bus.o_frame_done = (state_q == DONE);

    always_comb begin
        state_d   = state_q;
        in_col_d  = in_col_q;
        in_row_d  = in_row_q;
        beat_d    = beat_q;
        flush_d   = flush_q;
        oc_d      = oc_q;
        or_d      = or_q;
        ct_data_d = ct_data_q;
        ct_dval_d = 1'b0;
        ov_d      = 1'b0;
        ox_d      = ox_q;
        oy_d      = oy_q;
        bord_d    = bord_q;

        // The beat on the census input now has index beat_q; the census output
        // registers hold its centre pixel one clock later, once the window has filled.
        if (ct_dval_q) begin
            if (~&beat_q) beat_d = beat_q + 1'b1;
            if (beat_q >= BW'(FLUSH_LEN)) begin
                ov_d   = 1'b1;
                ox_d   = oc_q;
                oy_d   = or_q;
                bord_d = edge_pix;
                if (oc_q == CW'(M - 1)) begin
                    oc_d = '0;
                    or_d = or_q + 1'b1;
                end else begin
                    oc_d = oc_q + 1'b1;
                end
            end
        end

        unique case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    in_col_d = '0;
                    in_row_d = '0;
                    beat_d   = '0;
                    flush_d  = '0;
                    oc_d     = '0;
                    or_d     = '0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    ct_data_d = bus.i_pix_data;
                    ct_dval_d = 1'b1;
                    if (in_col_q == CW'(M - 1)) begin
                        in_col_d = '0;
                        in_row_d = in_row_q + 1'b1;
                        if (in_row_q == CW'(ROWS - 1)) state_d = FLUSH;
                    end else begin
                        in_col_d = in_col_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (flush_q != FW'(FLUSH_LEN)) begin
                    ct_data_d = '0;
                    ct_dval_d = 1'b1;
                    flush_d   = flush_q + 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= IDLE;
            in_col_q  <= '0;
            in_row_q  <= '0;
            beat_q    <= '0;
            flush_q   <= '0;
            oc_q      <= '0;
            or_q      <= '0;
            ct_data_q <= '0;
            ct_dval_q <= 1'b0;
            ov_q      <= 1'b0;
            ox_q      <= '0;
            oy_q      <= '0;
            bord_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_col_q  <= in_col_d;
            in_row_q  <= in_row_d;
            beat_q    <= beat_d;
            flush_q   <= flush_d;
            oc_q      <= oc_d;
            or_q      <= or_d;
            ct_data_q <= ct_data_d;
            ct_dval_q <= ct_dval_d;
            ov_q      <= ov_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            bord_q    <= bord_d;
        end
    end
endmodule
